// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// the stage payload record.
package imm_pkg;

  typedef enum logic [2:0] {
    MODE_ZERO   = 3'd0,
    MODE_SIGN   = 3'd1,
    MODE_LUI    = 3'd2,
    MODE_BRANCH = 3'd3,
    MODE_JUMP   = 3'd4,
    MODE_SHIFT  = 3'd5,
    MODE_RSV6   = 3'd6,
    MODE_RSV7   = 3'd7
  } imm_mode_t;

  localparam int unsigned PAYLOAD_W = 32;

  // Payload at the default datapath width; the stage builds an equivalent
  // record sized by its own DATA_W parameter.
  typedef struct packed {
    logic [PAYLOAD_W-1:0] imm;
    logic [PAYLOAD_W-1:0] simm;
    logic [PAYLOAD_W-1:0] target;
    logic                 err;
  } imm_payload_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: mode, instruction and PC to the
// extended immediate, its word-shifted copy and the next/branch/jump target.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIDX_W = 26,
  parameter int unsigned SHAMT  = 2
) (
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] simm,
  output logic [DATA_W-1:0] target,
  output logic              err
);

  logic [IMM_W-1:0]  field;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] lui;
  logic [DATA_W-1:0] jidx;
  logic [DATA_W-1:0] shfield;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] hi_mask;
  logic              unused_instr_hi;

  assign field   = instr[IMM_W-1:0];
  assign zext    = DATA_W'(field);
  assign sext    = {{(DATA_W-IMM_W){field[IMM_W-1]}}, field};
  assign lui     = {field, {(DATA_W-IMM_W){1'b0}}};
  assign jidx    = DATA_W'(instr[JIDX_W-1:0]);
  assign shfield = DATA_W'(instr[10:6]);
  assign pc4     = pc + DATA_W'(4);

  // Jump keeps the pc4 bits above the shifted index region.
  assign hi_mask = {DATA_W{1'b1}} << (JIDX_W + SHAMT);

  assign unused_instr_hi = ^instr[DATA_W-1:JIDX_W];

  always_comb begin
    imm    = '0;
    target = pc4;
    err    = 1'b0;
    case (mode)
      MODE_ZERO:   imm = zext;
      MODE_SIGN:   imm = sext;
      MODE_LUI:    imm = lui;
      MODE_BRANCH: begin
        imm    = sext;
        target = pc4 + (sext << SHAMT);
      end
      MODE_JUMP:   begin
        imm    = jidx;
        target = (pc4 & hi_mask) | (jidx << SHAMT);
      end
      MODE_SHIFT:  imm = shfield;
      default:     err = 1'b1;
    endcase
  end

  assign simm = imm << SHAMT;

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with a 2-entry main/skid buffer so
// in_ready comes straight from a flop and never from out_ready.
module imm_ext_stage
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIDX_W = 26,
  parameter int unsigned SHAMT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_simm,
  output logic [DATA_W-1:0] out_target,
  output logic              out_err
);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] target;
    logic              err;
  } stage_t;

  stage_t new_entry;
  stage_t main_q;
  stage_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   main_free;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .JIDX_W (JIDX_W),
    .SHAMT  (SHAMT)
  ) u_core (
    .mode   (in_mode),
    .instr  (in_instr),
    .pc     (in_pc),
    .imm    (new_entry.imm),
    .simm   (new_entry.simm),
    .target (new_entry.target),
    .err    (new_entry.err)
  );

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // Skid is older than any new entry, so it always refills main first.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= accept;
        if (accept) begin
          skid_q <= new_entry;
        end
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_q <= new_entry;
        end
      end
    end else if (accept) begin
      skid_q     <= new_entry;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign out_imm    = main_q.imm;
  assign out_simm   = main_q.simm;
  assign out_target = main_q.target;
  assign out_err    = main_q.err;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed mode, back-pressure, flush
// and reset steps followed by randomized traffic against a queue model.
module tb_imm_ext_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_simm;
  logic [31:0] out_target;
  logic        out_err;

  always #5 clk = ~clk;

  imm_ext_stage #(
    .DATA_W (32),
    .IMM_W  (16),
    .JIDX_W (26),
    .SHAMT  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_simm   (out_simm),
    .out_target (out_target),
    .out_err    (out_err)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  txn_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic imm_payload_t golden(input logic [2:0] mode,
                                          input logic [31:0] instr,
                                          input logic [31:0] pc);
    imm_payload_t p;
    logic [31:0]  pc4;
    logic [31:0]  f;
    logic [31:0]  sx;
    pc4      = pc + 32'd4;
    f        = instr & 32'h0000_FFFF;
    sx       = (f >= 32'h8000) ? f - 32'h0001_0000 : f;
    p.imm    = '0;
    p.err    = 1'b0;
    p.target = pc4;
    case (mode)
      3'd0: p.imm = f;
      3'd1: p.imm = sx;
      3'd2: p.imm = f * 32'h0001_0000;
      3'd3: begin
        p.imm    = sx;
        p.target = pc4 + sx * 32'd4;
      end
      3'd4: begin
        p.imm    = instr % 32'h0400_0000;
        p.target = (pc4 & 32'hF000_0000) + p.imm * 32'd4;
      end
      3'd5: p.imm = (instr / 32'd64) % 32'd32;
      default: p.err = 1'b1;
    endcase
    p.simm = p.imm * 32'd4;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    imm_payload_t p;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      p = golden(q[0].mode, q[0].instr, q[0].pc);
      chk("out_imm", out_imm, p.imm);
      chk("out_simm", out_simm, p.simm);
      chk("out_target", out_target, p.target);
      chk("out_err", 32'(out_err), 32'(p.err));
    end
  endtask

  // One clock: model consumes the inputs present at the edge, then compare.
  task automatic cycle();
    txn_t t;
    logic acc;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) q.delete(0);
      if (acc) begin
        t.mode  = in_mode;
        t.instr = in_instr;
        t.pc    = in_pc;
        q.push_back(t);
      end
    end
    check_state();
  endtask

  task automatic drive(input logic [2:0] m, input logic [31:0] ins, input logic [31:0] p);
    in_valid = 1'b1;
    in_mode  = m;
    in_instr = ins;
    in_pc    = p;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " out_imm"}, out_imm, 32'd0);
    chk({tag, " out_simm"}, out_simm, 32'd0);
    chk({tag, " out_target"}, out_target, 32'd0);
    chk({tag, " out_err"}, 32'(out_err), 32'd0);
  endtask

  initial begin
    logic r;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = '0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    check_cleared("reset");
    #6;
    reset = 1'b0;

    // Extension modes with a free-flowing output.
    drive(3'd1, 32'h2408_FFFC, 32'h0040_0000); cycle();
    chk("sign imm", out_imm, 32'hFFFF_FFFC);
    chk("sign simm", out_simm, 32'hFFFF_FFF0);
    drive(3'd0, 32'h2408_FFFC, 32'h0040_0000); cycle();
    chk("zero imm", out_imm, 32'h0000_FFFC);
    drive(3'd2, 32'h2408_FFFC, 32'h0040_0000); cycle();
    chk("lui imm", out_imm, 32'hFFFC_0000);
    drive(3'd3, 32'h2408_FFFC, 32'h0040_0000); cycle();
    chk("branch target", out_target, 32'h003F_FFF4);
    drive(3'd4, 32'h0810_0004, 32'h8000_000C); cycle();
    chk("jump imm", out_imm, 32'h0010_0004);
    chk("jump target", out_target, 32'h8040_0010);
    drive(3'd6, 32'h0810_0004, 32'h8000_000C); cycle();
    chk("rsv imm", out_imm, 32'd0);
    chk("rsv err", 32'(out_err), 32'd1);
    chk("rsv target", out_target, 32'h8000_0010);
    drive(3'd5, 32'h0000_07C0, 32'h0000_0000); cycle();
    chk("shift imm", out_imm, 32'h0000_001F);
    in_valid = 1'b0; cycle();

    // Back-pressure: A to main, B to skid, C held off until space frees.
    out_ready = 1'b0;
    drive(3'd0, 32'h0000_1111, 32'h100); cycle();
    drive(3'd0, 32'h0000_2222, 32'h200); cycle();
    chk("bp in_ready after B", 32'(in_ready), 32'd0);
    drive(3'd0, 32'h0000_3333, 32'h300); cycle(); cycle();
    chk("bp hold A", out_imm, 32'h0000_1111);
    out_ready = 1'b1; cycle();
    chk("bp second B", out_imm, 32'h0000_2222);
    cycle();
    chk("bp third C", out_imm, 32'h0000_3333);
    in_valid = 1'b0; cycle();
    chk("bp drained", 32'(out_valid), 32'd0);

    // Flush with both entries held and a same-cycle input.
    out_ready = 1'b0;
    drive(3'd0, 32'h0000_4444, 32'h0); cycle();
    drive(3'd0, 32'h0000_5555, 32'h0); cycle();
    flush = 1'b1;
    drive(3'd0, 32'h0000_6666, 32'h0); cycle();
    chk("flush full out_valid", 32'(out_valid), 32'd0);
    chk("flush full in_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    // Flush with only main held, so the dropped input sees in_ready=1.
    out_ready = 1'b0;
    drive(3'd0, 32'h0000_7777, 32'h0); cycle();
    flush = 1'b1;
    drive(3'd0, 32'h0000_8888, 32'h0); cycle();
    chk("flush main out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle();

    // Asynchronous reset between clock edges with entries in flight.
    out_ready = 1'b0;
    drive(3'd1, 32'h0000_9999, 32'h40); cycle();
    drive(3'd3, 32'h0000_AAAA, 32'h80); cycle();
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1 check_cleared("async reset");
    q.delete();
    #2 reset = 1'b0;
    out_ready = 1'b1;
    drive(3'd0, 32'h0000_BBBB, 32'h0); cycle();
    chk("post reset valid", 32'(out_valid), 32'd1);
    chk("post reset imm", out_imm, 32'h0000_BBBB);
    in_valid = 1'b0; cycle();

    // Random traffic; also probe that in_ready ignores out_ready mid-cycle.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      in_mode   = 3'($urandom % 8);
      in_instr  = $urandom;
      in_pc     = (($urandom % 16) == 0) ? 32'hFFFF_FFFC - 32'($urandom % 3) * 4 : $urandom;
      cycle();
      r = in_ready;
      out_ready = ~out_ready;
      #1;
      chk("in_ready vs out_ready", 32'(in_ready), 32'(r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
